// File: rtl/axi_burst_mem_slave_if.sv
// AXI4 bundle for a 32-bit memory-mapped port: AW, W, B, AR and R channels.
// Latency: none; this is wiring only.
// Backpressure: carried by the per-channel valid/ready pairs.
interface axi_burst_mem_slave_if #(
    parameter int ADDR_W = 12,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst memory slave: one write and one read burst at a time, independent paths, internal word RAM.
// Latency: B one cycle after the wlast beat; first R beat 2 cycles after AR, one bubble cycle between R beats.
// Backpressure: AW/AR refused while a burst is active; B and R outputs hold stable until bready/rready.
// Optional feature macro AXI_SLV_WRAP_BURST_EN enables WRAP bursts of 2/4/8/16 beats.
module axi_burst_mem_slave #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 1024
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    axi_burst_mem_slave_if.slave s_axi
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH * 4);
`ifdef AXI_SLV_WRAP_BURST_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < LIMIT;
    endfunction

    // Size and burst-type errors are known at the address handshake and hold for the whole burst.
    function automatic logic cfg_err(input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
        logic bad;
        bad = (size != 3'b010);
        if (burst == 2'b11)
            bad = 1'b1;
        if (burst == 2'b10)
            bad = bad | !WRAP_EN | !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return bad;
    endfunction

    // WRAP keeps the upper bits of an aligned (len+1)*4 window and increments inside it.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [1:0] burst,
                                                    input logic [7:0] len);
        logic [ADDR_W-1:0] inc;
        logic [ADDR_W-1:0] mask;
        inc  = a + ADDR_W'(4);
        mask = ADDR_W'({len, 2'b11});
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | (inc & mask);
            default: return inc;
        endcase
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;

    w_state_t w_state, w_next;
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len, w_cnt;
    logic [1:0]        w_burst;
    logic              w_err, w_slv, w_dec;

    r_state_t r_state, r_next;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len, r_cnt;
    logic [1:0]        r_burst;
    logic              r_err, r_dec;

    logic aw_hs, w_hs, ar_hs, r_hs;
    assign aw_hs = s_axi.awvalid & s_axi.awready;
    assign w_hs  = s_axi.wvalid & s_axi.wready;
    assign ar_hs = s_axi.arvalid & s_axi.arready;
    assign r_hs  = s_axi.rvalid & s_axi.rready;

    // Write FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    // Write FSM next state and channel handshakes.
    always_comb begin
        w_next        = w_state;
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi.awready = aresetn;
                if (s_axi.awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                s_axi.wready = 1'b1;
                if (s_axi.wvalid && s_axi.wlast) w_next = W_RESP;
            end
            W_RESP: begin
                s_axi.bvalid = 1'b1;
                if (s_axi.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write burst context: latch on AW, advance address and collect error flags per beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_id <= '0; w_addr <= '0; w_len <= '0; w_cnt <= '0; w_burst <= '0;
            w_err <= 1'b0; w_slv <= 1'b0; w_dec <= 1'b0;
        end else begin
            if (aw_hs) begin
                w_id    <= s_axi.awid;
                w_addr  <= s_axi.awaddr;
                w_len   <= s_axi.awlen;
                w_burst <= s_axi.awburst;
                w_err   <= cfg_err(s_axi.awsize, s_axi.awburst, s_axi.awlen);
                w_cnt   <= '0;
                w_slv   <= 1'b0;
                w_dec   <= 1'b0;
            end
            if (w_hs) begin
                w_addr <= next_addr(w_addr, w_burst, w_len);
                w_cnt  <= w_cnt + 8'd1;
                if (s_axi.wlast != (w_cnt == w_len)) w_slv <= 1'b1;
                if (!in_range(w_addr))               w_dec <= 1'b1;
            end
        end
    end

    assign s_axi.bid   = w_id;
    assign s_axi.bresp = (w_state != W_RESP) ? OKAY :
                         w_dec ? DECERR : (w_slv || w_err) ? SLVERR : OKAY;

    // Read FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    // Read FSM next state: each beat costs one RAM fetch cycle plus the data cycle.
    always_comb begin
        r_next        = r_state;
        s_axi.arready = 1'b0;
        s_axi.rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi.arready = aresetn;
                if (s_axi.arvalid) r_next = R_ADDR;
            end
            R_ADDR: r_next = R_DATA;
            R_DATA: begin
                s_axi.rvalid = 1'b1;
                if (s_axi.rready) r_next = (r_cnt == r_len) ? R_IDLE : R_ADDR;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read burst context: latch on AR, range-check at fetch time, advance on each R handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_id <= '0; r_addr <= '0; r_len <= '0; r_cnt <= '0; r_burst <= '0;
            r_err <= 1'b0; r_dec <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_id    <= s_axi.arid;
                r_addr  <= s_axi.araddr;
                r_len   <= s_axi.arlen;
                r_burst <= s_axi.arburst;
                r_err   <= cfg_err(s_axi.arsize, s_axi.arburst, s_axi.arlen);
                r_cnt   <= '0;
            end
            if (r_state == R_ADDR) r_dec <= !in_range(r_addr);
            if (r_hs) begin
                r_addr <= next_addr(r_addr, r_burst, r_len);
                r_cnt  <= r_cnt + 8'd1;
            end
        end
    end

    // RAM: byte-masked write, registered read; a same-cycle read of the written word sees old data.
    always_ff @(posedge aclk) begin
        if (w_hs && !w_err && in_range(w_addr)) begin
            for (int b = 0; b < DATA_W / 8; b++)
                if (s_axi.wstrb[b]) mem[w_addr[IDX_W+1:2]][8*b +: 8] <= s_axi.wdata[8*b +: 8];
        end
        if (r_state == R_ADDR) rd_q <= mem[r_addr[IDX_W+1:2]];
    end

    assign s_axi.rid   = r_id;
    assign s_axi.rdata = r_dec ? '0 : rd_q;
    assign s_axi.rlast = (r_state == R_DATA) && (r_cnt == r_len);
    assign s_axi.rresp = (r_state != R_DATA) ? OKAY :
                         r_dec ? DECERR : r_err ? SLVERR : OKAY;
endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Randomised bench for axi_burst_mem_slave against a word-array reference model.
// Latency: checks B one cycle after wlast, R first beat 2 cycles after AR, one bubble between beats.
// Backpressure: random wvalid gaps and bready/rready stalls; outputs must hold while stalled.
module tb_axi_burst_mem_slave;
    localparam int ADDR_W = 12;
    localparam int ID_W   = 4;
    localparam int DEPTH  = 1024;
    localparam int TMO    = 200;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi_burst_mem_slave_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) s_if ();
    axi_burst_mem_slave_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) s2_if ();

    axi_burst_mem_slave #(.ADDR_W(ADDR_W), .DATA_W(32), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn), .s_axi(s_if.slave));
    axi_burst_mem_slave #(.ADDR_W(ADDR_W), .DATA_W(32), .ID_W(ID_W), .DEPTH(512)) dut2 (
        .aclk(aclk), .aresetn(aresetn), .s_axi(s2_if.slave));

    logic [31:0] mem_m [DEPTH];
    logic [31:0] wd [512];
    logic [3:0]  ws [512];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte address of beat i, straight from the burst rules.
    function automatic int beat_addr(input int a, input int burst, input int len, input int i);
        int w;
        int base;
        if (burst == 0) return a;
        if (burst == 2) begin
            w = (len + 1) * 4;
            base = a - (a % w);
            return base + ((a - base + 4 * i) % w);
        end
        return (a + 4 * i) % 4096;
    endfunction

    function automatic bit cfg_bad(input int size, input int burst, input int len);
        if (size != 2 || burst == 3) return 1'b1;
        if (burst == 2) begin
`ifdef AXI_SLV_WRAP_BURST_EN
            return !(len == 1 || len == 3 || len == 7 || len == 15);
`else
            return 1'b1;
`endif
        end
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input int id, input int addr, input int len, input int size, input int burst,
                            input int nbeats, input bit bp);
        int t;
        int a;
        int exp_resp;
        bit bad;
        bad = cfg_bad(size, burst, len);
        s_if.awid = ID_W'(id); s_if.awaddr = ADDR_W'(addr); s_if.awlen = 8'(len);
        s_if.awsize = 3'(size); s_if.awburst = 2'(burst); s_if.awvalid = 1'b1;
        t = 0;
        while (!s_if.awready && t < TMO) begin tick(); t++; end
        check("aw_timeout", 32'(t >= TMO), 0);
        tick();
        s_if.awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (bp) repeat ($urandom_range(0, 2)) tick();
            s_if.wdata = wd[i]; s_if.wstrb = ws[i]; s_if.wlast = (i == nbeats - 1); s_if.wvalid = 1'b1;
            t = 0;
            while (!s_if.wready && t < TMO) begin tick(); t++; end
            if (t >= TMO) check("w_timeout", 32'(t), 0);
            tick();
            s_if.wvalid = 1'b0; s_if.wlast = 1'b0;
            if (!bad) begin
                a = beat_addr(addr, burst, len, i) / 4;
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) mem_m[a][8*b +: 8] = wd[i][8*b +: 8];
            end
        end
        exp_resp = (bad || nbeats != len + 1) ? 2 : 0;
        check("b_rise", 32'(s_if.bvalid), 1);
        t = 0;
        while (bp && $urandom_range(0, 1) == 0 && t < 8) begin
            tick(); t++;
            check("b_hold", 32'(s_if.bvalid), 1);
        end
        check("bresp", 32'(s_if.bresp), 32'(exp_resp));
        check("bid", 32'(s_if.bid), 32'(id));
        s_if.bready = 1'b1;
        tick();
        s_if.bready = 1'b0;
        check("b_fall", 32'(s_if.bvalid), 0);
    endtask

    task automatic do_read(input int id, input int addr, input int len, input int size, input int burst,
                           input bit bp);
        int t;
        int a;
        int exp_resp;
        bit bad;
        logic [31:0] exp_dat;
        bad = cfg_bad(size, burst, len);
        s_if.arid = ID_W'(id); s_if.araddr = ADDR_W'(addr); s_if.arlen = 8'(len);
        s_if.arsize = 3'(size); s_if.arburst = 2'(burst); s_if.arvalid = 1'b1;
        t = 0;
        while (!s_if.arready && t < TMO) begin tick(); t++; end
        check("ar_timeout", 32'(t >= TMO), 0);
        tick();
        s_if.arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            t = 0;
            while (!s_if.rvalid && t < TMO) begin tick(); t++; end
            check(i == 0 ? "r_latency" : "r_bubble", 32'(t), 1);
            a = beat_addr(addr, burst, len, i);
            exp_resp = (a >= DEPTH * 4) ? 3 : bad ? 2 : 0;
            exp_dat  = (a >= DEPTH * 4) ? 32'h0 : mem_m[a / 4];
            while (bp && $urandom_range(0, 2) == 0) begin
                s_if.rready = 1'b0;
                tick();
                check("r_hold_vld", 32'(s_if.rvalid), 1);
                check("r_hold_last", 32'(s_if.rlast), 32'(i == len));
                if (!bad) check("r_hold_dat", s_if.rdata, exp_dat);
            end
            if (!bad) check("rdata", s_if.rdata, exp_dat);
            check("rresp", 32'(s_if.rresp), 32'(exp_resp));
            check("rid", 32'(s_if.rid), 32'(id));
            check("rlast", 32'(s_if.rlast), 32'(i == len));
            s_if.rready = 1'b1;
            tick();
            s_if.rready = 1'b0;
        end
        check("r_done", 32'(s_if.rvalid), 0);
    endtask

    // Read on the 512-word instance; only the response and zeroed DECERR data are of interest.
    task automatic d2_read(input int addr, input int len);
        int t;
        int a;
        s2_if.arid = 4'h3; s2_if.araddr = ADDR_W'(addr); s2_if.arlen = 8'(len);
        s2_if.arsize = 3'b010; s2_if.arburst = 2'b01; s2_if.arvalid = 1'b1;
        t = 0;
        while (!s2_if.arready && t < TMO) begin tick(); t++; end
        tick();
        s2_if.arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            t = 0;
            while (!s2_if.rvalid && t < TMO) begin tick(); t++; end
            check("d2_timeout", 32'(t >= TMO), 0);
            a = addr + 4 * i;
            check("d2_rresp", 32'(s2_if.rresp), (a >= 2048) ? 32'd3 : 32'd0);
            if (a >= 2048) check("d2_rdata", s2_if.rdata, 32'h0);
            s2_if.rready = 1'b1;
            tick();
            s2_if.rready = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int a;
        int len;
        int burst;
        int r;
        s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = '0; s_if.awsize = '0; s_if.awburst = '0;
        s_if.awvalid = 0; s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 0; s_if.wvalid = 0;
        s_if.bready = 0; s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = '0;
        s_if.arburst = '0; s_if.arvalid = 0; s_if.rready = 0;
        s2_if.awid = '0; s2_if.awaddr = '0; s2_if.awlen = '0; s2_if.awsize = '0; s2_if.awburst = '0;
        s2_if.awvalid = 0; s2_if.wdata = '0; s2_if.wstrb = '0; s2_if.wlast = 0; s2_if.wvalid = 0;
        s2_if.bready = 0; s2_if.arid = '0; s2_if.araddr = '0; s2_if.arlen = '0; s2_if.arsize = '0;
        s2_if.arburst = '0; s2_if.arvalid = 0; s2_if.rready = 0;
        repeat (3) tick();
        check("rst_outputs", {20'h0, s_if.awready, s_if.wready, s_if.bvalid, s_if.arready, s_if.rvalid,
                              s_if.rlast, s_if.bresp, s_if.rresp, s_if.bid[1:0]}, 0);
        aresetn = 1'b1;
        tick();
        check("idle_ready", 32'({s_if.awready, s_if.arready}), 3);

        // Fill the whole RAM so every later read has a defined expectation.
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            do_write(1, blk * 1024, 255, 2, 1, 256, 1'b0);
        end

        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
        do_write(5, 'h100, 3, 2, 1, 4, 1'b0);
        do_read(5, 'h100, 3, 2, 1, 1'b0);

        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        do_write(2, 'h40, 0, 2, 1, 1, 1'b0);
        wd[0] = 32'h1122_3344; ws[0] = 4'b0101;
        do_write(2, 'h40, 0, 2, 1, 1, 1'b0);
        check("strb_model", mem_m[16], 32'hFF22_FF44);
        do_read(2, 'h40, 0, 2, 1, 1'b0);

        do_read(6, 'hFFC, 1, 2, 1, 1'b0);
        do_read(7, 'h200, 15, 2, 1, 1'b1);

        for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0DE_0000 + i; ws[i] = 4'hF; end
        do_write(8, 'h300, 3, 2, 1, 2, 1'b0);
        do_write(8, 'h320, 1, 2, 1, 3, 1'b0);
        do_read(9, 'h300, 3, 1, 1, 1'b0);
        do_read(9, 'h300, 3, 2, 1, 1'b0);

        for (int i = 0; i < 4; i++) begin wd[i] = 32'h5A00_0000 + i; ws[i] = 4'hF; end
        do_write(10, 'h108, 3, 2, 2, 4, 1'b0);
        do_read(10, 'h108, 3, 2, 2, 1'b0);
        do_read(10, 'h100, 3, 2, 1, 1'b0);
        do_write(11, 'h380, 1, 2, 3, 2, 1'b0);
        do_read(11, 'h380, 1, 2, 1, 1'b0);
        do_write(12, 'h3C0, 3, 2, 0, 4, 1'b0);
        do_read(12, 'h3C0, 0, 2, 1, 1'b0);

        d2_read('h7FC, 1);
        d2_read('h800, 0);

        for (int it = 0; it < 40; it++) begin
            a = $urandom_range(0, 1023) * 4;
            len = $urandom_range(0, 15);
            r = $urandom_range(0, 9);
            burst = (r < 4) ? 1 : (r < 6) ? 0 : (r < 9) ? 2 : 3;
            if (burst == 2 && $urandom_range(0, 3) != 0) len = (2 << $urandom_range(0, 3)) - 1;
            for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            do_write($urandom_range(0, 15), a, len, ($urandom_range(0, 7) == 0) ? 1 : 2, burst, len + 1, 1'b1);
            do_read($urandom_range(0, 15), a, len, ($urandom_range(0, 7) == 0) ? 1 : 2,
                    (burst == 3) ? 1 : burst, 1'b1);
        end

        // Abort an erroring write and a long read mid-burst with reset.
        s_if.arid = 4'h1; s_if.araddr = 12'h400; s_if.arlen = 8'd15; s_if.arsize = 3'b010;
        s_if.arburst = 2'b01; s_if.arvalid = 1'b1;
        s_if.awid = 4'h2; s_if.awaddr = 12'h400; s_if.awlen = 8'd7; s_if.awsize = 3'b001;
        s_if.awburst = 2'b01; s_if.awvalid = 1'b1;
        tick();
        s_if.arvalid = 1'b0; s_if.awvalid = 1'b0;
        s_if.wdata = 32'hDEAD_BEEF; s_if.wstrb = 4'hF; s_if.wvalid = 1'b1;
        tick();
        s_if.wvalid = 1'b0;
        t = 0;
        while (!s_if.rvalid && t < TMO) begin tick(); t++; end
        check("pre_abort", 32'({s_if.rvalid, s_if.wready}), 3);
        #2 aresetn = 1'b0;
        #1 check("abort_outputs", 32'({s_if.awready, s_if.wready, s_if.bvalid, s_if.arready, s_if.rvalid}), 0);
        #13 aresetn = 1'b1;
        tick();
        wd[0] = 32'h600D_F00D; ws[0] = 4'hF;
        do_write(3, 'h400, 0, 2, 1, 1, 1'b0);
        do_read(3, 'h400, 1, 2, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
